// File: rtl/divider.sv
// -----------------------------------------------------------------------------
// divider
//   Sequential unsigned restoring divider. Produces one quotient bit per clock
//   and returns quotient and remainder through a single-outstanding valid/ready
//   handshake. A zero divisor still runs the full iteration. The result is then
//   forced to quotient = all ones, remainder = 0 and div_zero = 1.
//
//   Optional build macro: DIVIDER_FAST_PATH_EN
//     When this macro is defined, operands with dividend < divisor or with
//     divisor == 0 skip the iteration and complete one cycle after acceptance.
//     The results are the same as in the default build.
//
// Ports
//   clk_i        in   1    clock, rising edge
//   rst_i        in   1    synchronous active-high reset
//   in_valid_i   in   1    operands valid
//   in_ready_o   out  1    divider can accept operands (IDLE only)
//   dividend_i   in   DW   unsigned dividend (DIVIDEND_WIDTH)
//   divisor_i    in   SW   unsigned divisor (DIVISOR_WIDTH)
//   out_valid_o  out  1    result valid (DONE only)
//   out_ready_i  in   1    consumer accepts result
//   quotient_o   out  DW   floor(dividend / divisor)
//   remainder_o  out  SW   dividend mod divisor
//   div_zero_o   out  1    divisor was zero, qualified by out_valid_o
// -----------------------------------------------------------------------------
module divider #(
  parameter int DIVIDEND_WIDTH = 16,
  parameter int DIVISOR_WIDTH  = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [DIVIDEND_WIDTH-1:0] dividend_i,
  input  logic [DIVISOR_WIDTH-1:0]  divisor_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [DIVIDEND_WIDTH-1:0] quotient_o,
  output logic [DIVISOR_WIDTH-1:0]  remainder_o,
  output logic                      div_zero_o
);

  localparam int CW = (DIVIDEND_WIDTH > 1) ? $clog2(DIVIDEND_WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                    r_state;
  logic [CW-1:0]             r_count;
  // The dividend shifts out of the MSB while quotient bits shift into the LSB.
  logic [DIVIDEND_WIDTH-1:0] r_work;
  logic [DIVISOR_WIDTH-1:0]  r_divisor;
  // The stored partial remainder is always below the divisor, so it needs only
  // DIVISOR_WIDTH bits. The shifted value w_rem_shift carries the extra bit.
  logic [DIVISOR_WIDTH-1:0]  r_rem;
  logic                      r_dz;
  logic                      r_in_ready;
  logic                      r_out_valid;
  logic [DIVIDEND_WIDTH-1:0] r_quotient;
  logic [DIVISOR_WIDTH-1:0]  r_remainder;
  logic                      r_div_zero;

  logic [DIVISOR_WIDTH:0]    w_rem_shift;
  logic                      w_ge;
  logic [DIVISOR_WIDTH-1:0]  w_rem_next;
  logic [DIVIDEND_WIDTH-1:0] w_quot_next;

  assign w_rem_shift = {r_rem, r_work[DIVIDEND_WIDTH-1]};
  assign w_ge        = (w_rem_shift >= {1'b0, r_divisor});
  assign w_quot_next = (r_work << 1'b1) | DIVIDEND_WIDTH'(w_ge);

  // Restoring step: after a subtraction the true result is below the divisor,
  // so an arithmetic result of DIVISOR_WIDTH bits is exact.
  always_comb begin
    w_rem_next = w_rem_shift[DIVISOR_WIDTH-1:0];
    if (w_ge) begin
      w_rem_next = w_rem_shift[DIVISOR_WIDTH-1:0] - r_divisor;
    end else begin
      w_rem_next = w_rem_shift[DIVISOR_WIDTH-1:0];
    end
  end

`ifdef DIVIDER_FAST_PATH_EN
  logic w_fast;
  assign w_fast = (divisor_i == '0) || (dividend_i < DIVIDEND_WIDTH'(divisor_i));
`endif

  // Control FSM, datapath and registered handshake outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_work      <= '0;
      r_divisor   <= '0;
      r_rem       <= '0;
      r_dz        <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_div_zero  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid_i) begin
            r_work     <= dividend_i;
            r_divisor  <= divisor_i;
            r_dz       <= (divisor_i == '0);
            r_count    <= CW'(DIVIDEND_WIDTH - 1);
            r_rem      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_BUSY;
`ifdef DIVIDER_FAST_PATH_EN
            if (w_fast) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              if (divisor_i == '0) begin
                r_quotient  <= '1;
                r_remainder <= '0;
                r_div_zero  <= 1'b1;
              end else begin
                r_quotient  <= '0;
                r_remainder <= dividend_i[DIVISOR_WIDTH-1:0];
                r_div_zero  <= 1'b0;
              end
            end
`endif
          end
        end
        S_BUSY: begin
          r_rem  <= w_rem_next;
          r_work <= w_quot_next;
          if (r_count == '0) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            if (r_dz) begin
              r_quotient  <= '1;
              r_remainder <= '0;
              r_div_zero  <= 1'b1;
            end else begin
              r_quotient  <= w_quot_next;
              r_remainder <= w_rem_next;
              r_div_zero  <= 1'b0;
            end
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready_i) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign quotient_o  = r_quotient;
  assign remainder_o = r_remainder;
  assign div_zero_o  = r_div_zero;

endmodule
